// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style character LCD controller.
// Includes the command record, the sequencer states and the slow-command decode.
package lcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        WAIT
    } lcd_state_e;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } lcd_cmd_t;

    localparam logic [7:0] LCD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_HOME  = 8'h02;

    // Clear and return-home are the only instructions that need the long
    // execution wait. Both have zero in bits 7:2 and a non-zero value in bits 1:0.
    function automatic logic is_slow_cmd(input lcd_cmd_t cmd);
        return !cmd.rs
            && ((cmd.data & ~(LCD_CLEAR | LCD_HOME)) == 8'h00)
            && (cmd.data != 8'h00);
    endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Small synchronous FIFO of LCD commands. It lets the producer keep issuing
// stores while the slow LCD works through earlier commands.
module lcd_cmd_fifo
    import lcd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  logic     pop,
    input  lcd_cmd_t wr_data,
    output lcd_cmd_t rd_data,
    output logic     full,
    output logic     empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    lcd_cmd_t      mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + (AW + 1)'(1);
            2'b01:   count_next = count - (AW + 1)'(1);
            default: count_next = count;
        endcase
    end

    // Full and empty are registered so ready never has a combinational
    // path from the producer's valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            full  <= (count_next == FULL_COUNT);
            empty <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/lcd_ctrl.sv
// Write-only 8-bit HD44780 sequencer. It pops queued commands and drives
// RS/data, then an EN pulse, then the command's execution wait.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int T_SETUP    = 2,
    parameter int T_PULSE    = 12,
    parameter int T_HOLD     = 2,
    parameter int T_CMD_WAIT = 2000,
    parameter int T_CLR_WAIT = 80000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_cmd_valid,
    input  logic       i_cmd_rs,
    input  logic [7:0] i_cmd_data,
    output logic       o_cmd_ready,
    input  logic       i_lcd_on,
    output logic       o_busy,
    output logic       o_lcd_on,
    output logic       o_lcd_en,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic [7:0] o_lcd_data
);

    localparam int T_MAX_A = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
    localparam int T_MAX_B = (T_MAX_A > T_HOLD) ? T_MAX_A : T_HOLD;
    localparam int T_MAX_C = (T_MAX_B > T_CMD_WAIT) ? T_MAX_B : T_CMD_WAIT;
    localparam int T_MAX   = (T_MAX_C > T_CLR_WAIT) ? T_MAX_C : T_CLR_WAIT;
    localparam int CW      = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    lcd_state_e    state;
    lcd_state_e    state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [CW-1:0] wait_len;
    logic [CW-1:0] wait_len_next;
    lcd_cmd_t      cmd_in;
    lcd_cmd_t      head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;

    assign cmd_in      = '{rs: i_cmd_rs, data: i_cmd_data};
    assign push        = i_cmd_valid && !fifo_full;
    assign o_cmd_ready = !fifo_full;
    assign o_lcd_rw    = 1'b0;

    lcd_cmd_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (i_clk),
        .reset  (i_reset),
        .push   (push),
        .pop    (pop),
        .wr_data(cmd_in),
        .rd_data(head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // A single down-counter times every phase. It is loaded with duration-1
    // on entry, and the phase ends when the counter reads zero.
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        wait_len_next = wait_len;
        pop           = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop           = 1'b1;
                    state_next    = SETUP;
                    cnt_next      = CW'(T_SETUP - 1);
                    wait_len_next = is_slow_cmd(head) ? CW'(T_CLR_WAIT - 1)
                                                      : CW'(T_CMD_WAIT - 1);
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_next = PULSE;
                    cnt_next   = CW'(T_PULSE - 1);
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    state_next = HOLD;
                    cnt_next   = CW'(T_HOLD - 1);
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_next = WAIT;
                    cnt_next   = wait_len;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Busy is registered from the upcoming state. It therefore rises on the
    // pop edge and falls on the edge that returns to IDLE with nothing queued.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= IDLE;
            cnt        <= '0;
            wait_len   <= '0;
            o_lcd_en   <= 1'b0;
            o_lcd_rs   <= 1'b0;
            o_lcd_data <= 8'h00;
            o_lcd_on   <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            wait_len <= wait_len_next;
            o_lcd_en <= (state_next == PULSE);
            o_lcd_on <= i_lcd_on;
            o_busy   <= (state_next != IDLE) || (!fifo_empty && !pop);
            if (pop) begin
                o_lcd_rs   <= head.rs;
                o_lcd_data <= head.data;
            end
        end
    end

endmodule
